multiply_pipe: RTL and testbench

//  Pipelined, stallable Baugh-Wooley multiplier with per-transaction operand signedness.

---
 rtl/multiply_pkg.sv | 21 ++
 rtl/multiply_pipe_stage.sv | 83 ++++++++
 rtl/multiply_pipe.sv | 80 ++++++++
 tb/tb_multiply_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/multiply_pkg.sv
// Shared helpers for the pipelined Baugh-Wooley multiplier: row partitioning
// and the constant that compensates the inverted sign-row/sign-column terms.
package multiply_pkg;

  localparam int max_acc_width = 128;

  // Rows per stage for an operand extended to width+1 bits, rounded up.
  function automatic int bw_rows_per_stage(input int width, input int stages);
    return (width + stages) / stages;
  endfunction

  // 2^n + 2^(2n-1), truncated by the caller to its 2n-bit accumulator.
  function automatic logic [max_acc_width-1:0] bw_correction(input int n);
    logic [max_acc_width-1:0] c;
    c = '0;
    c[n] = 1'b1;
    c[2*n-1] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/multiply_pipe_stage.sv
// One pipeline stage: adds its share of partial-product rows to the running
// accumulator and holds the result until the downstream stage can take it.
module multiply_pipe_stage
  import multiply_pkg::*;
#(
  parameter int p_n         = 5,
  parameter int p_tag_width = 4,
  parameter int p_row_base  = 0,
  parameter int p_row_count = 1,
  parameter bit p_first     = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   prev_valid,
  input  logic [2*p_n-1:0]       prev_acc,
  input  logic [p_n-1:0]         prev_a_x,
  input  logic [p_n-1:0]         prev_b_x,
  input  logic [p_tag_width-1:0] prev_tag,
  input  logic                   next_adv,
  output logic                   adv,
  output logic                   valid,
  output logic [2*p_n-1:0]       acc,
  output logic [p_n-1:0]         a_x,
  output logic [p_n-1:0]         b_x,
  output logic [p_tag_width-1:0] tag
);

  typedef struct packed {
    logic [2*p_n-1:0]       acc;
    logic [p_n-1:0]         a_x;
    logic [p_n-1:0]         b_x;
    logic [p_tag_width-1:0] tag;
  } payload_t;

  localparam logic [max_acc_width-1:0] corr_full = bw_correction(p_n);
  localparam logic [2*p_n-1:0]         corr      = p_first ? corr_full[2*p_n-1:0] : '0;

  payload_t payload_q;
  payload_t payload_d;
  logic     valid_q;

  // Row j: a_x gated by b_x[j], shifted by j; terms touching exactly one
  // sign bit are inverted so the whole sum can be done unsigned.
  function automatic logic [2*p_n-1:0] bw_row(input logic [p_n-1:0] a,
                                               input logic [p_n-1:0] b,
                                               input int j);
    logic [2*p_n-1:0] row;
    row = '0;
    for (int i = 0; i < p_n; i++)
      row[i+j] = (a[i] & b[j]) ^ ((i == p_n-1) != (j == p_n-1));
    return row;
  endfunction

  always_comb begin
    payload_d.acc = prev_acc + corr;
    for (int r = 0; r < p_row_count; r++)
      payload_d.acc = payload_d.acc + bw_row(prev_a_x, prev_b_x, p_row_base + r);
    payload_d.a_x = prev_a_x;
    payload_d.b_x = prev_b_x;
    payload_d.tag = prev_tag;
  end

  // An empty stage always advances, so bubbles are squeezed out under stall.
  assign adv = !valid_q | next_adv;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else if (adv) begin
      valid_q <= prev_valid;
      if (prev_valid)
        payload_q <= payload_d;
    end
  end

  assign valid = valid_q;
  assign acc   = payload_q.acc;
  assign a_x   = payload_q.a_x;
  assign b_x   = payload_q.b_x;
  assign tag   = payload_q.tag;

endmodule

// File: rtl/multiply_pipe.sv
// Stallable pipelined Baugh-Wooley multiplier with per-operation signedness
// and an opaque tag carried alongside each product.
module multiply_pipe
  import multiply_pkg::*;
#(
  parameter int p_width     = 4,
  parameter int p_stages    = 2,
  parameter int p_tag_width = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [p_width-1:0]     a_i,
  input  logic [p_width-1:0]     b_i,
  input  logic                   a_signed_i,
  input  logic                   b_signed_i,
  input  logic [p_tag_width-1:0] tag_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [2*p_width-1:0]   product_o,
  output logic [p_tag_width-1:0] tag_o
);

  localparam int n      = p_width + 1;
  localparam int rows_r = bw_rows_per_stage(p_width, p_stages);

  logic [p_stages:0]      adv;
  logic [p_stages-1:0]    v;
  logic [2*n-1:0]         acc   [p_stages];
  logic [n-1:0]           a_x   [p_stages];
  logic [n-1:0]           b_x   [p_stages];
  logic [p_tag_width-1:0] tag_q [p_stages];
  logic [n-1:0]           a_ext;
  logic [n-1:0]           b_ext;
  logic                   unused_bits;

  assign a_ext = {a_signed_i & a_i[p_width-1], a_i};
  assign b_ext = {b_signed_i & b_i[p_width-1], b_i};

  assign adv[p_stages] = ready_i;

  for (genvar k = 0; k < p_stages; k++) begin : g_stage
    localparam int base  = k * rows_r;
    localparam int count = (base >= n) ? 0 : ((n - base < rows_r) ? n - base : rows_r);

    if (k == 0) begin : g_first
      multiply_pipe_stage #(
        .p_n(n), .p_tag_width(p_tag_width),
        .p_row_base(base), .p_row_count(count), .p_first(1'b1)
      ) u_stage (
        .clk_i(clk_i), .reset_i(reset_i),
        .prev_valid(valid_i), .prev_acc('0),
        .prev_a_x(a_ext), .prev_b_x(b_ext), .prev_tag(tag_i),
        .next_adv(adv[k+1]), .adv(adv[k]), .valid(v[k]),
        .acc(acc[k]), .a_x(a_x[k]), .b_x(b_x[k]), .tag(tag_q[k])
      );
    end else begin : g_rest
      multiply_pipe_stage #(
        .p_n(n), .p_tag_width(p_tag_width),
        .p_row_base(base), .p_row_count(count), .p_first(1'b0)
      ) u_stage (
        .clk_i(clk_i), .reset_i(reset_i),
        .prev_valid(v[k-1]), .prev_acc(acc[k-1]),
        .prev_a_x(a_x[k-1]), .prev_b_x(b_x[k-1]), .prev_tag(tag_q[k-1]),
        .next_adv(adv[k+1]), .adv(adv[k]), .valid(v[k]),
        .acc(acc[k]), .a_x(a_x[k]), .b_x(b_x[k]), .tag(tag_q[k])
      );
    end
  end

  assign ready_o   = adv[0];
  assign valid_o   = v[p_stages-1];
  assign product_o = acc[p_stages-1][2*p_width-1:0];
  assign tag_o     = tag_q[p_stages-1];

  // The top two accumulator bits only repeat the sign of the product.
  assign unused_bits = ^{acc[p_stages-1][2*n-1:2*p_width], a_x[p_stages-1], b_x[p_stages-1]};

endmodule

// File: tb/tb_multiply_pipe.sv
// Bench for multiply_pipe: directed handshake scenarios plus a random sweep,
// with every accepted operation predicted by a plain-arithmetic reference.
module tb_multiply_pipe;

  localparam int W  = 4;
  localparam int S  = 2;
  localparam int TW = 4;

  typedef struct packed {
    logic [2*W-1:0] prod;
    logic [TW-1:0]  tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  a_i;
  logic [W-1:0]  b_i;
  logic          a_signed_i;
  logic          b_signed_i;
  logic [TW-1:0] tag_i;
  logic          valid_o;
  logic          ready_i;
  logic [2*W-1:0] product_o;
  logic [TW-1:0] tag_o;

  int   n_checks   = 0;
  int   n_fail     = 0;
  int   n_accepted = 0;
  exp_t sb[$];
  exp_t e_mon;

  multiply_pipe #(.p_width(W), .p_stages(S), .p_tag_width(TW)) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .a_signed_i(a_signed_i), .b_signed_i(b_signed_i),
    .tag_i(tag_i), .valid_o(valid_o), .ready_i(ready_i),
    .product_o(product_o), .tag_o(tag_o)
  );

  always #5 clk = ~clk;

  // Reference: interpret each operand per its flag, multiply as integers.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic as, input logic bs);
    longint av, bv, p;
    av = longint'(a);
    bv = longint'(b);
    if (as && a[W-1]) av = av - (longint'(1) << W);
    if (bs && b[W-1]) bv = bv - (longint'(1) << W);
    p = av * bv;
    return p[2*W-1:0];
  endfunction

  task automatic check_output(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic as, input logic bs, input logic [TW-1:0] t);
    valid_i    = 1'b1;
    a_i        = a;
    b_i        = b;
    a_signed_i = as;
    b_signed_i = bs;
    tag_i      = t;
  endtask

  task automatic apply_random();
    apply_stimulus(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), TW'($urandom));
  endtask

  task automatic single_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic as,
                           input logic bs, input logic [TW-1:0] t, input logic [2*W-1:0] exp,
                           input string name);
    ready_i = 1'b1;
    apply_stimulus(a, b, as, bs, t);
    step();
    valid_i = 1'b0;
    check_output({name, "_latency"}, 64'(valid_o), 64'(0));
    step();
    check_output({name, "_valid"}, 64'(valid_o), 64'(1));
    check_output({name, "_product"}, 64'(product_o), 64'(exp));
    check_output({name, "_tag"}, 64'(tag_o), 64'(t));
    step();
  endtask

  // Scoreboard: handshakes are judged mid-cycle, before the edge that commits them.
  always @(negedge clk) begin
    if (reset_i) begin
      sb.delete();
    end else begin
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          check_output("spurious_valid", 64'(valid_o), 64'(0));
        end else begin
          e_mon = sb.pop_front();
          check_output("sb_product", 64'(product_o), 64'(e_mon.prod));
          check_output("sb_tag", 64'(tag_o), 64'(e_mon.tag));
        end
      end
      if (valid_i && ready_o) begin
        e_mon.prod = ref_mul(a_i, b_i, a_signed_i, b_signed_i);
        e_mon.tag  = tag_i;
        sb.push_back(e_mon);
        n_accepted++;
      end
    end
  end

  initial begin
    int             acc0;
    int             last;
    logic [2*W-1:0] held;

    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    apply_stimulus('0, '0, 1'b0, 1'b0, '0);
    valid_i = 1'b0;
    step();
    step();
    reset_i = 1'b0;
    check_output("reset_valid_o", 64'(valid_o), 64'(0));
    check_output("reset_ready_o", 64'(ready_o), 64'(1));
    check_output("reset_product_o", 64'(product_o), 64'(0));
    check_output("reset_tag_o", 64'(tag_o), 64'(0));

    $display("[TB] directed sign combinations");
    single_op(4'h8, 4'h8, 1'b1, 1'b1, 4'hA, 8'h40, "ss_min");
    single_op(4'hF, 4'hF, 1'b0, 1'b0, 4'h3, 8'hE1, "uu_max");
    single_op(4'hF, 4'hF, 1'b1, 1'b0, 4'h5, 8'hF1, "su");
    single_op(4'h3, 4'hE, 1'b0, 1'b1, 4'h9, 8'hFA, "us");

    $display("[TB] back-to-back stream");
    ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      apply_random();
      tag_i = TW'(i);
      step();
      if (i >= 1) check_output("stream_valid", 64'(valid_o), 64'(1));
    end
    valid_i = 1'b0;
    step();
    check_output("stream_last_valid", 64'(valid_o), 64'(1));
    step();
    check_output("stream_drained", 64'(valid_o), 64'(0));

    $display("[TB] stall with full pipe");
    ready_i = 1'b0;
    acc0 = n_accepted;
    last = n_accepted;
    apply_random();
    held = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 1) held = product_o;
      if (n_accepted != last) begin
        last = n_accepted;
        apply_random();
      end
    end
    check_output("stall_accepted", 64'(n_accepted - acc0), 64'(S));
    check_output("stall_ready_o", 64'(ready_o), 64'(0));
    check_output("stall_valid_o", 64'(valid_o), 64'(1));
    check_output("stall_product_stable", 64'(product_o), 64'(held));
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_output("stall_no_loss", 64'(sb.size()), 64'(0));

    $display("[TB] bubble collapse");
    ready_i = 1'b0;
    acc0 = n_accepted;
    apply_random();
    step();
    apply_random();
    #1;
    check_output("bubble_ready_o", 64'(ready_o), 64'(1));
    step();
    valid_i = 1'b0;
    check_output("bubble_accepted", 64'(n_accepted - acc0), 64'(2));
    check_output("bubble_full_ready_o", 64'(ready_o), 64'(0));
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_output("bubble_no_loss", 64'(sb.size()), 64'(0));

    $display("[TB] reset with ops in flight");
    ready_i = 1'b1;
    apply_random();
    step();
    apply_random();
    step();
    valid_i = 1'b0;
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check_output("flush_valid_o", 64'(valid_o), 64'(0));
    check_output("flush_ready_o", 64'(ready_o), 64'(1));
    check_output("flush_product_o", 64'(product_o), 64'(0));
    check_output("flush_tag_o", 64'(tag_o), 64'(0));
    for (int i = 0; i < 4; i++) begin
      step();
      check_output("flush_no_stale", 64'(valid_o), 64'(0));
    end

    $display("[TB] random sweep");
    last = n_accepted;
    valid_i = 1'b0;
    for (int i = 0; i < 400; i++) begin
      ready_i = ($urandom_range(3) != 0);
      if (!valid_i || n_accepted != last) begin
        last = n_accepted;
        apply_random();
        valid_i = ($urandom_range(2) != 0);
      end
      step();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check_output("sweep_drained", 64'(sb.size()), 64'(0));
    check_output("sweep_idle_valid_o", 64'(valid_o), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
